// File: rtl/ctrl_multiciclo_pkg.sv
// ctrl_multiciclo_pkg
// Shared definitions for the multi-cycle controller: FSM state codes,
// opcode constants, ALU operation codes, the control-word bundle passed
// from the strobe decoder to the top, and an opcode classifier used by
// both the next-state logic and the decoder.
package ctrl_multiciclo_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_BEQ  = 4'b0111;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Instruction classes; every opcode not listed explicitly is a NOP.
   typedef enum logic [2:0] {
      CL_NOP,
      CL_RTYPE,
      CL_ADDI,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_JMP,
      CL_HALT
   } op_class_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_src;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic op_class_e classify(input logic [3:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CL_RTYPE;
         OP_ADDI:                       cls = CL_ADDI;
         OP_LW:                         cls = CL_LW;
         OP_SW:                         cls = CL_SW;
         OP_BEQ:                        cls = CL_BEQ;
         OP_JMP:                        cls = CL_JMP;
         OP_HALT:                       cls = CL_HALT;
         default:                       cls = CL_NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ctrl_multiciclo_decod.sv
// ctrl_decod
// Combinational strobe decoder: maps the current FSM state and the latched
// opcode to the datapath control word.
// Ports:
//   state_i  : current FSM state
//   op_q_i   : opcode latched at the end of DECODE (used from EXEC onward)
//   opcode_i : live opcode from the IR (only looked at during DECODE, before
//              op_q has been loaded)
//   zero_i   : ALU zero flag, gates the BEQ branch
//   ctrl_o   : control word (ungated; the top masks it while in reset)
module ctrl_decod
   import ctrl_multiciclo_pkg::*;
(
   input  state_e     state_i,
   input  logic [3:0] op_q_i,
   input  logic [3:0] opcode_i,
   input  logic       zero_i,
   output ctrl_t      ctrl_o
);

   op_class_e cls_q;
   op_class_e cls_live;

   assign cls_q    = classify(op_q_i);
   assign cls_live = classify(opcode_i);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.ir_write = 1'b1;
            ctrl_o.pc_write = 1'b1;
            ctrl_o.pc_src   = 1'b0;
         end
         ST_DECODE: begin
            // op_q is still being loaded this cycle, so the jump decision
            // has to come from the IR directly.
            if (cls_live == CL_JMP) begin
               ctrl_o.pc_write = 1'b1;
               ctrl_o.pc_src   = 1'b1;
            end
         end
         ST_EXEC: begin
            case (cls_q)
               CL_RTYPE: ctrl_o.alu_op = op_q_i[1:0];
               CL_ADDI, CL_LW, CL_SW: begin
                  ctrl_o.alu_src = 1'b1;
                  ctrl_o.alu_op  = ALU_ADD;
               end
               CL_BEQ: begin
                  ctrl_o.alu_op   = ALU_SUB;
                  ctrl_o.pc_write = zero_i;
                  ctrl_o.pc_src   = zero_i;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            ctrl_o.mem_read  = (cls_q == CL_LW);
            ctrl_o.mem_write = (cls_q == CL_SW);
         end
         ST_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_src   = (cls_q == CL_LW);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo
// Multi-cycle processor controller: Moore FSM (FETCH/DECODE/EXEC/MEM/WB/HALT),
// latched opcode, retired-instruction counter, and strobe decode through
// ctrl_decod.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   opcode[3:0]         : instruction[7:4] from the IR, valid from DECODE
//   zero                : ALU zero flag (BEQ)
//   mem_ready           : memory done handshake (only with MEM_WAIT_EN)
//   pc_write, pc_src    : PC load enable / select (0 = PC+1, 1 = target)
//   ir_write            : IR load enable
//   mem_read, mem_write : memory strobes
//   reg_write, reg_src  : register write enable / source (1 = memory)
//   alu_src, alu_op     : ALU operand select / operation
//   state[2:0]          : current FSM state code
//   halted              : high while in HALT
//   instr_count[7:0]    : retired-instruction counter (wraps)
// Configuration:
//   MEM_WAIT_EN defined   -> FETCH and MEM stall while mem_ready is low,
//                            keeping their strobes asserted.
//   MEM_WAIT_EN undefined -> mem_ready is ignored, every access is one cycle.
module ctrl_multiciclo
   import ctrl_multiciclo_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_src,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic [2:0] state,
   output logic       halted,
   output logic [7:0] instr_count
);

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [7:0] count_q, count_d;
   // Cleared by reset, set on the first edge afterwards: keeps strobes low
   // during reset and delays the first FETCH until that edge.
   logic       run_q;
   logic       retire;
   logic       mem_ok;
   op_class_e  cls_live;
   op_class_e  cls_q;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl_out;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   assign cls_live = classify(opcode);
   assign cls_q    = classify(op_q);

   // Next state. retire marks the last cycle of an instruction, so the
   // counter steps on the edge that leaves it (including HALT entry).
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      retire  = 1'b0;
      if (run_q) begin
         case (state_q)
            ST_FETCH: begin
               if (mem_ok) state_d = ST_DECODE;
            end
            ST_DECODE: begin
               op_d = opcode;
               case (cls_live)
                  CL_RTYPE, CL_ADDI, CL_LW, CL_SW, CL_BEQ: state_d = ST_EXEC;
                  CL_HALT: begin
                     state_d = ST_HALT;
                     retire  = 1'b1;
                  end
                  default: begin
                     // JMP and NOP finish here.
                     state_d = ST_FETCH;
                     retire  = 1'b1;
                  end
               endcase
            end
            ST_EXEC: begin
               case (cls_q)
                  CL_RTYPE, CL_ADDI: state_d = ST_WB;
                  CL_LW, CL_SW:      state_d = ST_MEM;
                  CL_BEQ: begin
                     state_d = ST_FETCH;
                     retire  = 1'b1;
                  end
                  default:           state_d = ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (mem_ok) begin
                  case (cls_q)
                     CL_LW: state_d = ST_WB;
                     CL_SW: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                     end
                     default: state_d = ST_FETCH;
                  endcase
               end
            end
            ST_WB: begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
         endcase
      end
      count_d = retire ? count_q + 8'd1 : count_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         op_q    <= 4'd0;
         count_q <= 8'd0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         run_q   <= 1'b1;
      end
   end

   ctrl_decod u_decod (
      .state_i  (state_q),
      .op_q_i   (op_q),
      .opcode_i (opcode),
      .zero_i   (zero),
      .ctrl_o   (dec_ctrl)
   );

   assign ctrl_out = run_q ? dec_ctrl : '0;

   assign pc_write    = ctrl_out.pc_write;
   assign pc_src      = ctrl_out.pc_src;
   assign ir_write    = ctrl_out.ir_write;
   assign mem_read    = ctrl_out.mem_read;
   assign mem_write   = ctrl_out.mem_write;
   assign reg_write   = ctrl_out.reg_write;
   assign reg_src     = ctrl_out.reg_src;
   assign alu_src     = ctrl_out.alu_src;
   assign alu_op      = ctrl_out.alu_op;
   assign state       = state_q;
   assign halted      = (state_q == ST_HALT);
   assign instr_count = count_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Testbench for ctrl_multiciclo. Each planned cycle carries the stimulus to
// drive and the outputs the controller must show in that cycle; the driver
// pushes the expectation into a scoreboard queue as it drives, and the
// checker pops it on the following falling edge.
module tb_ctrl_multiciclo;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_src, ir_write, mem_read, mem_write;
   logic       reg_write, reg_src, alu_src;
   logic [1:0] alu_op;
   logic [2:0] state;
   logic       halted;
   logic [7:0] instr_count;

   always #5 clk = ~clk;

   ctrl_multiciclo dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .ir_write    (ir_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .reg_src     (reg_src),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .state       (state),
      .halted      (halted),
      .instr_count (instr_count)
   );

`ifdef MEM_WAIT_EN
   localparam logic MR_DONE = 1'b1;
`else
   // Without wait support mem_ready must be ignored, so drive it low.
   localparam logic MR_DONE = 1'b0;
`endif

   // Strobe vector order: pc_write pc_src ir_write mem_read mem_write
   //                      reg_write reg_src alu_src alu_op[1:0]
   localparam logic [9:0] SB_NONE  = 10'b0000000000;
   localparam logic [9:0] SB_FETCH = 10'b1011000000;
   localparam logic [9:0] SB_JMP   = 10'b1100000000;
   localparam logic [9:0] SB_IMM   = 10'b0000000100;
   localparam logic [9:0] SB_WBALU = 10'b0000010000;
   localparam logic [9:0] SB_WBMEM = 10'b0000011000;
   localparam logic [9:0] SB_MEMRD = 10'b0001000000;
   localparam logic [9:0] SB_MEMWR = 10'b0000100000;

   typedef struct {
      logic       rst;
      logic [3:0] op;
      logic       z;
      logic       mr;
      logic [2:0] st;
      logic [9:0] sb;
      logic [7:0] cnt;
      logic       hl;
   } cyc_t;

   cyc_t       plan_q[$];
   cyc_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic void push(input logic rst, input logic [3:0] op, input logic z,
                                input logic mr, input logic [2:0] st, input logic [9:0] sb,
                                input logic hl);
      cyc_t c;
      c.rst = rst; c.op = op; c.z = z; c.mr = mr;
      c.st = st; c.sb = sb; c.cnt = exp_cnt; c.hl = hl;
      plan_q.push_back(c);
   endfunction

   // Reset cycle plus the idle cycle after release (no strobes until the
   // first edge with reset low).
   task automatic add_reset();
      exp_cnt = 8'd0;
      push(1'b1, 4'd0, 1'b0, 1'b0, 3'd0, SB_NONE, 1'b0);
      push(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, SB_NONE, 1'b0);
   endtask

   // Plan one instruction. The IR is driven with the complement of the
   // opcode outside DECODE so that any use of the live opcode is visible.
   task automatic add_instr(input logic [3:0] op, input logic z, input int wf, input int wm);
      logic [3:0] nop;
      nop = ~op;
      for (int i = 0; i < wf; i++) push(1'b0, nop, z, 1'b0, 3'd0, SB_FETCH, 1'b0);
      push(1'b0, nop, z, MR_DONE, 3'd0, SB_FETCH, 1'b0);
      push(1'b0, op, z, 1'b0, 3'd1, (op == 4'b1000) ? SB_JMP : SB_NONE, 1'b0);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            push(1'b0, nop, z, 1'b0, 3'd2, {8'd0, op[1:0]}, 1'b0);
            push(1'b0, nop, z, 1'b0, 3'd4, SB_WBALU, 1'b0);
         end
         4'd4: begin
            push(1'b0, nop, z, 1'b0, 3'd2, SB_IMM, 1'b0);
            push(1'b0, nop, z, 1'b0, 3'd4, SB_WBALU, 1'b0);
         end
         4'd5: begin
            push(1'b0, nop, z, 1'b0, 3'd2, SB_IMM, 1'b0);
            for (int i = 0; i < wm; i++) push(1'b0, nop, z, 1'b0, 3'd3, SB_MEMRD, 1'b0);
            push(1'b0, nop, z, MR_DONE, 3'd3, SB_MEMRD, 1'b0);
            push(1'b0, nop, z, 1'b0, 3'd4, SB_WBMEM, 1'b0);
         end
         4'd6: begin
            push(1'b0, nop, z, 1'b0, 3'd2, SB_IMM, 1'b0);
            for (int i = 0; i < wm; i++) push(1'b0, nop, z, 1'b0, 3'd3, SB_MEMWR, 1'b0);
            push(1'b0, nop, z, MR_DONE, 3'd3, SB_MEMWR, 1'b0);
         end
         4'd7: push(1'b0, nop, z, 1'b0, 3'd2, {z, z, 6'd0, 2'b01}, 1'b0);
         default: ;
      endcase
      exp_cnt = exp_cnt + 8'd1;
   endtask

   task automatic add_halt_cycles(input int n);
      for (int i = 0; i < n; i++)
         push(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 3'd5, SB_NONE, 1'b1);
   endtask

   task automatic run_plan(input string what);
      cyc_t c;
      cyc_t e;
      int   n;
      n = plan_q.size();
      while (plan_q.size() > 0) begin
         c = plan_q.pop_front();
         reset     = c.rst;
         opcode    = c.op;
         zero      = c.z;
         mem_ready = c.mr;
         sb_q.push_back(c);
         @(negedge clk);
         e = sb_q.pop_front();
         check_eq({what, "/state"}, 32'(state), 32'(e.st));
         check_eq({what, "/strobes"},
                  32'({pc_write, pc_src, ir_write, mem_read, mem_write,
                       reg_write, reg_src, alu_src, alu_op}), 32'(e.sb));
         check_eq({what, "/count"}, 32'(instr_count), 32'(e.cnt));
         check_eq({what, "/halted"}, 32'(halted), 32'(e.hl));
         @(posedge clk);
         #1;
      end
      $display("%s: %0d cycles, instr_count=%0d", what, n, instr_count);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] op;
      logic       z;
      reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
      exp_cnt = 8'd0;

      add_reset();
      run_plan("reset");

      // Every opcode once (except HALT), then BEQ taken and not taken.
      for (int k = 0; k < 15; k++) begin
         op = 4'(k);
         z  = 1'($urandom_range(0, 1));
         add_instr(op, z, 0, 0);
         run_plan($sformatf("op=%b z=%0d", op, z));
      end
      add_instr(4'b0111, 1'b1, 0, 0);
      run_plan("BEQ z=1");
      add_instr(4'b0111, 1'b0, 0, 0);
      run_plan("BEQ z=0");

      for (int k = 0; k < 12; k++) begin
         op = 4'($urandom_range(0, 14));
         z  = 1'($urandom_range(0, 1));
         add_instr(op, z, 0, 0);
         run_plan($sformatf("rand op=%b z=%0d", op, z));
      end

      // ADD interrupted by reset during EXEC.
      push(1'b0, 4'b1111, 1'b0, MR_DONE, 3'd0, SB_FETCH, 1'b0);
      push(1'b0, 4'b0000, 1'b0, 1'b0, 3'd1, SB_NONE, 1'b0);
      push(1'b0, 4'b1111, 1'b0, 1'b0, 3'd2, SB_NONE, 1'b0);
      add_reset();
      run_plan("ADD reset mid-EXEC");

      // 256 NOPs from zero: counter wraps back to zero.
      for (int k = 0; k < 256; k++) begin
         add_instr(4'b1010, 1'($urandom_range(0, 1)), 0, 0);
         run_plan($sformatf("NOP %0d", k));
      end
      check_eq("wrap", 32'(instr_count), 32'd0);

      add_instr(4'b1111, 1'b0, 0, 0);
      add_halt_cycles(20);
      run_plan("HALT");

      add_reset();
      run_plan("reset after HALT");

`ifdef MEM_WAIT_EN
      add_instr(4'b0110, 1'b0, 0, 3);
      run_plan("SW mem wait 3");
      add_instr(4'b0101, 1'b0, 2, 1);
      run_plan("LW fetch wait 2 mem wait 1");
`endif
      add_instr(4'b0101, 1'b0, 0, 0);
      run_plan("LW");
      add_instr(4'b0110, 1'b1, 0, 0);
      run_plan("SW");
      add_instr(4'b0000, 1'b0, 0, 0);
      run_plan("ADD");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_multiciclo.md
CTRL_MULTICICLO -- requirements
Module: ctrl_multiciclo

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: single clock, rising-edge active.
REQ-002 SHALL have reset `reset`, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL have `opcode`, input, 4 bits: instruction[7:4] from IR, valid from DECODE onward.
REQ-004 SHALL have `zero`, input, 1 bit: ALU zero flag.
REQ-005 SHALL have `mem_ready`, input, 1 bit: memory done; used only with MEM_WAIT_EN.
REQ-006 SHALL have `pc_write`, output, 1 bit: PC load enable.
REQ-007 SHALL have `pc_src`, output, 1 bit: 0 = PC+1, 1 = branch/jump target.
REQ-008 SHALL have `ir_write`, output, 1 bit: IR load enable.
REQ-009 SHALL have `mem_read` and `mem_write`, outputs, 1 bit each: memory strobes.
REQ-010 SHALL have `reg_write`, output, 1 bit: register bank write enable.
REQ-011 SHALL have `reg_src`, output, 1 bit: 1 = write-back from memory, 0 = from ALU.
REQ-012 SHALL have `alu_src`, output, 1 bit: 1 = immediate, 0 = register.
REQ-013 SHALL have `alu_op`, output, 2 bits: 00 add, 01 sub, 10 and, 11 or.
REQ-014 SHALL have `state`, output, 3 bits: current FSM state code.
REQ-015 SHALL have `halted`, output, 1 bit: high while in HALT.
REQ-016 SHALL have `instr_count`, output, 8 bits: retired-instruction counter.

Function
REQ-017 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH.
REQ-018 SHALL, in FETCH, assert mem_read, ir_write and pc_write with pc_src=0, then go to DECODE.
REQ-019 SHALL latch opcode into op_q in DECODE; all later decoding SHALL use op_q.
REQ-020 SHALL decode opcodes as follows:
- 0000–0011: ADD/SUB/AND/OR, path EXEC -> WB.
- 0100: ADDI, path EXEC -> WB.
- 0101: LW, path EXEC -> MEM -> WB.
- 0110: SW, path EXEC -> MEM.
- 0111: BEQ, path EXEC.
- 1000: JMP, path DECODE only.
- 1111: HALT.
- All others: NOP, return from DECODE to FETCH.
REQ-021 SHALL, for JMP, assert pc_write with pc_src=1 in DECODE, then go to FETCH.
REQ-022 SHALL set alu_op in EXEC as follows: op_q[1:0] for R-type, 01 for BEQ, 00 otherwise; alu_src=1 for ADDI, LW and SW.
REQ-023 SHALL, for BEQ in EXEC, assert pc_write with pc_src=1 only when zero=1, then go to FETCH.
REQ-024 SHALL, in MEM, assert mem_read for LW and mem_write for SW; SW then goes to FETCH and LW goes to WB.
REQ-025 SHALL, in WB, assert reg_write, with reg_src=1 for LW and 0 otherwise, then go to FETCH.
REQ-026 SHALL hold all strobes low in any state or instruction not listed above.
REQ-027 SHALL increment instr_count by 1 on the last cycle of each instruction, including NOP, JMP and HALT entry; it SHALL wrap from 255 to 0.
REQ-028 SHALL keep HALT absorbing: all strobes low and instr_count frozen until reset.
REQ-029 SHALL take exactly the following cycle counts per instruction: R-type/ADDI 4, LW 5, SW 4, BEQ 3, JMP 2, NOP 2.

Reset
REQ-030 SHALL, on reset assertion at any time (including mid-instruction), immediately force state=FETCH, op_q=0, instr_count=0 and halted=0.
REQ-031 SHALL hold all strobes low while reset is high; FETCH strobes SHALL begin on the first edge after deassertion.

Configuration
REQ-032 SHALL, when MEM_WAIT_EN is defined, hold FETCH and MEM while mem_ready=0, keep strobes asserted during the hold, and not count wait cycles in REQ-029.
REQ-033 SHALL, when MEM_WAIT_EN is undefined, ignore mem_ready and treat every memory access as single-cycle.

Structure
REQ-034 SHALL place state codes, opcode constants and alu_op codes in shared package `ctrl_multiciclo_pkg`.
REQ-035 SHALL use one sub-module, `ctrl_decod`: combinational op_q + state -> strobe decode; the FSM and counter stay in the top.

Verification
REQ-036 SHALL verify reset mid-EXEC of ADD: next cycle state=0, instr_count=0, all strobes 0.
REQ-037 SHALL verify opcode 0101 (LW): state sequence 0,1,2,3,4; mem_read in cycles 1 and 4; reg_write=1 and reg_src=1 in cycle 5; instr_count +1.
REQ-038 SHALL verify BEQ 0111 with zero=1: pc_write=1 and pc_src=1 in EXEC; with zero=0: pc_write=0 in EXEC; both take 3 cycles.
REQ-039 SHALL verify 256 NOPs (opcode 1010): instr_count wraps to 0, each NOP takes 2 cycles.
REQ-040 SHALL verify HALT 1111: state=5 and halted=1 held for 20 cycles with all strobes 0 and instr_count frozen.
REQ-041 SHALL verify, with MEM_WAIT_EN, SW with mem_ready=0 for 3 cycles: MEM held 3 extra cycles with mem_write high, then FETCH.
